fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly around the program counter register. It reads `ppc`, issues instruction-memory requests at that address, and drives `next_pc` back into the PC register every cycle: hold when stalled, increment after a fetch, or a branch target on redirect. Fetched instructions go to decode through a valid/ready handshake, buffered by an output register plus a one-entry skid register.

## Interface
- `PC_WIDTH`, 8, program counter / instruction address width
- `INST_WIDTH`, 16, instruction word width
- `clock`  in  1  single clock, all state on rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `ppc`  in  PC_WIDTH  current PC from the PC register
- `next_pc`  out  PC_WIDTH  value the PC register loads on the next rising edge
- `imem_req`  out  1  fetch request, level
- `imem_addr`  out  PC_WIDTH  fetch address, always equal to `ppc`
- `imem_ack`  in  1  memory returns `imem_rdata` for the current `imem_addr` this cycle
- `imem_rdata`  in  INST_WIDTH  instruction word, valid only with `imem_ack`
- `branch_taken`  in  1  single-cycle redirect pulse from execute
- `branch_target`  in  PC_WIDTH  redirect address, valid with `branch_taken`
- `inst_valid`  out  1  output register holds an instruction
- `inst`  out  INST_WIDTH  instruction to decode
- `inst_pc`  out  PC_WIDTH  address `inst` was fetched from
- `inst_ready`  in  1  decode accepts `inst` this cycle

## Operation
- Reset values while `clear` is high: state S_REQ, `inst_valid`=0, `inst`=0, `inst_pc`=0, skid empty and zeroed, `imem_req`=0, `next_pc`=8'h00.
- Memory protocol: `imem_ack` acknowledges whatever address is present in that cycle. The address may change while `imem_req` is high without an ack. Ack may arrive in the same cycle as the request.
- The output register is free when `!inst_valid || inst_ready`.
- State S_REQ: `imem_req`=1, `next_pc`=`ppc` unless an ack arrives.
  - On ack with the output register free: write `imem_rdata`/`ppc` into the output register, `next_pc`=`ppc`+1, stay in S_REQ.
  - On ack with the output register not free: write into the skid, `next_pc`=`ppc`+1, go to S_FULL.
- State S_FULL: `imem_req`=0, `next_pc`=`ppc`. On `inst_ready`, move skid to the output register (`inst_valid` stays 1), empty the skid, go to S_REQ.
- With no new write, `inst_valid` clears after a handshake (`inst_valid && inst_ready`).
- Redirect (`branch_taken`) has highest priority:
  - `next_pc`=`branch_target`.
  - Any ack in that cycle is discarded.
  - Output register and skid are invalidated next cycle.
  - State goes to S_REQ.
- Arithmetic: `ppc`+1 is modulo 2^PC_WIDTH, so 8'hFF wraps to 8'h00.

## Timing
- Ack in cycle N: `inst_valid` high in cycle N+1. The PC register holds `ppc`+1 in cycle N+1.
- With a single-cycle-ack memory and `inst_ready` held high, throughput is 1 instruction per cycle.
- Redirect in cycle N: `ppc`=`branch_target` and `inst_valid`=0 in cycle N+1. The first target instruction is valid no earlier than N+2.
- Redirect together with a handshake in cycle N: decode keeps the consumed instruction (squashing it is execute's responsibility). The buffers are cleared anyway.
- `inst`, `inst_pc` and `inst_valid` stay stable while `inst_valid && !inst_ready`.
- `clear` asserted mid-operation: outputs go to their reset values asynchronously. Fetch restarts at 8'h00 on the first edge after deassertion.
- `next_pc`, `imem_req` and `imem_addr` are combinational from state, `ppc`, ack and redirect. Every other output is registered.

## Structure
- Shared package `cpu_pkg`:
  - `PC_WIDTH`, `INST_WIDTH`, `RESET_PC`=8'h00
  - fetch state enum {S_REQ, S_FULL}
- Natural sub-module: `fetch_buffer`, the two-entry output-plus-skid register with valid/ready, flush and full flag.
- The top level holds the FSM and the `next_pc` mux.

## Test plan
- Reset then steady fetch: release `clear`, memory acks every cycle with rdata=16'hA000+addr, `inst_ready`=1 -> `inst_pc` sequence 00,01,02,… one per cycle, `inst`=16'hA000+`inst_pc`, first `inst_valid` one cycle after the first ack.
- Backpressure: `inst_ready`=0 for 4 cycles starting with `inst_pc`=03 -> skid fills with 04, state S_FULL, `imem_req`=0, `next_pc`=`ppc`=05 held. On release, 03, 04, 05 are delivered in order with no loss or duplication.
- Redirect: `branch_taken` with target 8'h40 in a cycle where ack arrives for addr 07 -> 07 is never delivered, `inst_valid`=0 next cycle, next delivered `inst_pc`=40.
- Wrap-around: fetch at `ppc`=8'hFF with ack -> `next_pc`=8'h00, following instruction has `inst_pc`=00.
- Slow memory: ack only every third cycle -> `next_pc`=`ppc` on non-ack cycles, `inst_valid` pulses match the acks, PC advances exactly once per ack.
- Mid-stream clear: assert `clear` while S_FULL with both entries valid -> `inst_valid`=0, `imem_req`=0 immediately; after release, fetch resumes at 00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector and fetch FSM states.
package cpu_pkg;

  localparam int PC_WIDTH   = 8;
  localparam int INST_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_FULL = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch buffer: an output register facing decode plus a one-entry
// skid register that catches a fetch returning while decode is stalled.
module fetch_buffer #(
  parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [INST_WIDTH-1:0] wr_inst_i,
  input  logic [PC_WIDTH-1:0]   wr_pc_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [INST_WIDTH-1:0] rd_inst_o,
  output logic [PC_WIDTH-1:0]   rd_pc_o,
  output logic                  free_o,
  output logic                  full_o
);

  logic                  out_valid_q, out_valid_d;
  logic [INST_WIDTH-1:0] out_inst_q,  out_inst_d;
  logic [PC_WIDTH-1:0]   out_pc_q,    out_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [INST_WIDTH-1:0] skid_inst_q,  skid_inst_d;
  logic [PC_WIDTH-1:0]   skid_pc_q,    skid_pc_d;

  assign free_o = !out_valid_q || rd_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Drain the skid first so program order is preserved.
      if (rd_ready_i) begin
        out_valid_d  = 1'b1;
        out_inst_d   = skid_inst_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (wr_en_i && free_o) begin
      out_valid_d = 1'b1;
      out_inst_d  = wr_inst_i;
      out_pc_d    = wr_pc_i;
    end else if (wr_en_i) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = wr_inst_i;
      skid_pc_d    = wr_pc_i;
    end else if (out_valid_q && rd_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign rd_valid_o = out_valid_q;
  assign rd_inst_o  = out_inst_q;
  assign rd_pc_o    = out_pc_q;
  assign full_o     = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage around the PC register: issues fetches at ppc,
// steers next_pc (hold / increment / redirect) and buffers results for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [PC_WIDTH-1:0]   ppc,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  fetch_state_e state_q;
  logic         fetch_ack;
  logic         buf_wr;
  logic         buf_free;
  logic         buf_full;

  // An ack only counts while a request is outstanding; a redirect discards it.
  assign fetch_ack = imem_ack && (state_q == S_REQ) && !clear;
  assign buf_wr    = fetch_ack && !branch_taken;
  assign imem_req  = (state_q == S_REQ) && !clear;
  assign imem_addr = ppc;

  always_comb begin
    next_pc = ppc;
    if (clear)
      next_pc = RST_PC;
    else if (branch_taken)
      next_pc = branch_target;
    else if (fetch_ack)
      next_pc = ppc + PC_ONE;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_REQ;
    end else if (branch_taken) begin
      state_q <= S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (fetch_ack && !buf_free) state_q <= S_FULL;
        S_FULL:  if (inst_ready || !buf_full) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

  fetch_buffer #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_buf (
    .clk_i      (clock),
    .rst_i      (clear),
    .flush_i    (branch_taken),
    .wr_en_i    (buf_wr),
    .wr_inst_i  (imem_rdata),
    .wr_pc_i    (ppc),
    .rd_ready_i (inst_ready),
    .rd_valid_o (inst_valid),
    .rd_inst_o  (inst),
    .rd_pc_o    (inst_pc),
    .free_o     (buf_free),
    .full_o     (buf_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bench-side PC register and a memory
// that returns 16'hA000 + address whenever ack is enabled.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  ppc;
  logic [7:0]  next_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        inst_valid;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_ready = 1'b0;
  logic        ack_en = 1'b0;

  int passed = 0;
  int total  = 0;

  fetch_unit dut (
    .clock         (clock),
    .clear         (clear),
    .ppc           (ppc),
    .next_pc       (next_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ppc <= next_pc;

  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = 16'hA000 + {8'h00, imem_addr};

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b1; ack_en = 1'b0; inst_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    repeat (2) @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    clear = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid); else passed++;
    total++; if (inst !== 16'h0000) $display("FAIL reset_inst: got %h want 0000", inst); else passed++;
    total++; if (inst_pc !== 8'h00) $display("FAIL reset_inst_pc: got %h want 00", inst_pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else passed++;
    total++; if (next_pc !== 8'h00) $display("FAIL reset_next_pc: got %h want 00", next_pc); else passed++;
    total++; if (dut.state_q !== S_REQ) $display("FAIL reset_state: got %0d want S_REQ", dut.state_q); else passed++;
    clear = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) $display("FAIL post_reset_req: got %0b want 1", imem_req); else passed++;
    total++; if (next_pc !== 8'h00) $display("FAIL post_reset_hold: got %h want 00", next_pc); else passed++;
  endtask

  task automatic test_steady();
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1;
    #1;
    total++; if (next_pc !== 8'h01) $display("FAIL steady_first_next: got %h want 01", next_pc); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL steady_not_yet: got %0b want 0", inst_valid); else passed++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 8'(i) || inst !== 16'hA000 + 16'(i))
        $display("FAIL steady_%0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, 8'(i), 16'hA000 + 16'(i));
      else passed++;
      total++; if (ppc !== 8'(i + 1)) $display("FAIL steady_ppc_%0d: got %h want %h", i, ppc, 8'(i + 1)); else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1;
    repeat (4) @(negedge clock);
    total++; if (inst_pc !== 8'h03) $display("FAIL bp_start: got %h want 03", inst_pc); else passed++;
    inst_ready = 1'b0;
    @(negedge clock);
    #1;
    total++; if (dut.state_q !== S_FULL) $display("FAIL bp_state: got %0d want S_FULL", dut.state_q); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL bp_req: got %0b want 0", imem_req); else passed++;
    total++; if (next_pc !== 8'h05 || ppc !== 8'h05) $display("FAIL bp_pc: got next=%h ppc=%h want 05 05", next_pc, ppc); else passed++;
    total++; if (dut.u_buf.skid_pc_q !== 8'h04 || dut.u_buf.skid_valid_q !== 1'b1)
      $display("FAIL bp_skid: got v=%0b pc=%h want v=1 pc=04", dut.u_buf.skid_valid_q, dut.u_buf.skid_pc_q);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h03 || inst !== 16'hA003 || next_pc !== 8'h05)
        $display("FAIL bp_hold_%0d: got v=%0b pc=%h inst=%h next=%h want 1 03 A003 05", i, inst_valid, inst_pc, inst, next_pc);
      else passed++;
    end
    inst_ready = 1'b1;
    for (int i = 4; i < 7; i++) begin
      @(negedge clock);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 8'(i) || inst !== 16'hA000 + 16'(i))
        $display("FAIL bp_drain_%0d: got v=%0b pc=%h inst=%h want pc=%h", i, inst_valid, inst_pc, inst, 8'(i));
      else passed++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1;
    repeat (7) @(negedge clock);
    branch_taken = 1'b1; branch_target = 8'h40;
    #1;
    total++; if (next_pc !== 8'h40) $display("FAIL br_next: got %h want 40", next_pc); else passed++;
    @(negedge clock);
    total++; if (inst_valid !== 1'b0 || ppc !== 8'h40) $display("FAIL br_flush: got v=%0b ppc=%h want 0 40", inst_valid, ppc); else passed++;
    branch_taken = 1'b0;
    #1;
    total++; if (next_pc !== 8'h41) $display("FAIL br_fetch: got %h want 41", next_pc); else passed++;
    @(negedge clock);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h40 || inst !== 16'hA040)
      $display("FAIL br_target: got v=%0b pc=%h inst=%h want 1 40 A040", inst_valid, inst_pc, inst);
    else passed++;
    @(negedge clock);
    total++; if (inst_pc !== 8'h41) $display("FAIL br_follow: got %h want 41", inst_pc); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 8'hFF;
    @(negedge clock);
    branch_taken = 1'b0;
    #1;
    total++; if (ppc !== 8'hFF || next_pc !== 8'h00) $display("FAIL wrap_next: got ppc=%h next=%h want FF 00", ppc, next_pc); else passed++;
    @(negedge clock);
    total++; if (inst_pc !== 8'hFF || inst !== 16'hA0FF || ppc !== 8'h00)
      $display("FAIL wrap_ff: got pc=%h inst=%h ppc=%h want FF A0FF 00", inst_pc, inst, ppc);
    else passed++;
    @(negedge clock);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst !== 16'hA000)
      $display("FAIL wrap_00: got v=%0b pc=%h inst=%h want 1 00 A000", inst_valid, inst_pc, inst);
    else passed++;
  endtask

  task automatic test_slow_memory();
    logic       prev_ack;
    logic [7:0] exp_pc;
    do_reset();
    inst_ready = 1'b1;
    prev_ack = 1'b0;
    exp_pc = 8'h00;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      total++; if (inst_valid !== prev_ack || ppc !== exp_pc)
        $display("FAIL slow_%0d: got v=%0b ppc=%h want v=%0b ppc=%h", c, inst_valid, ppc, prev_ack, exp_pc);
      else passed++;
      ack_en = (c % 3 == 2);
      #1;
      total++; if (next_pc !== (ack_en ? exp_pc + 8'h01 : exp_pc))
        $display("FAIL slow_next_%0d: got %h want %h", c, next_pc, ack_en ? exp_pc + 8'h01 : exp_pc);
      else passed++;
      prev_ack = ack_en;
      if (ack_en) exp_pc = exp_pc + 8'h01;
    end
  endtask

  task automatic test_clear_mid();
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1;
    repeat (4) @(negedge clock);
    inst_ready = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL clr_outputs: got v=%0b req=%0b want 0 0", inst_valid, imem_req);
    else passed++;
    total++; if (next_pc !== 8'h00 || dut.u_buf.skid_valid_q !== 1'b0)
      $display("FAIL clr_state: got next=%h skid=%0b want 00 0", next_pc, dut.u_buf.skid_valid_q);
    else passed++;
    @(negedge clock);
    clear = 1'b0; inst_ready = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL clr_restart: got req=%0b addr=%h want 1 00", imem_req, imem_addr); else passed++;
    @(negedge clock);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) $display("FAIL clr_first: got v=%0b pc=%h want 1 00", inst_valid, inst_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_slow_memory();
    test_clear_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
